// File: rtl/test_sequencer_pkg.sv
// Shared types and width helper for the test sequencer and its synchronizer.
package test_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } seq_state_t;

    // Bit width needed to hold values 0..v-1, never less than one bit.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/test_sequencer_sync.sv
// Two-flop synchronizer bank for level signals arriving from another clock domain.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/test_sequencer.sv
// Runs a bank of test units one at a time: pulse start, wait for sticky finish
// or a cycle timeout, then report which units hung.
module test_sequencer
    import test_seq_pkg::*;
#(
    parameter int N_TESTS = 4,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = $clog2(TIMEOUT),
    parameter int IDX_W   = clog2_min1(N_TESTS),
    parameter int FC_W    = clog2_min1(N_TESTS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               go,
    input  logic [N_TESTS-1:0] finish,
    output logic [N_TESTS-1:0] start,
    output logic               busy,
    output logic               done,
    output logic [IDX_W-1:0]   cur_idx,
    output logic [N_TESTS-1:0] timeout_mask,
    output logic [FC_W-1:0]    fail_count
);

    seq_state_t         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_idx;
    logic [N_TESTS-1:0] r_start;
    logic               r_busy;
    logic               r_done;
    logic [N_TESTS-1:0] r_mask;
    logic [FC_W-1:0]    r_fail;

    logic [N_TESTS-1:0] w_finish_s;
    logic               w_cur_fin;
    logic               w_cnt_max;
    logic               w_last;

    sync_2ff #(.W(N_TESTS)) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (finish),
        .o_q (w_finish_s)
    );

    assign w_cur_fin = w_finish_s[r_idx];
    assign w_cnt_max = (r_cnt == CNT_W'(TIMEOUT - 1));
    assign w_last    = (r_idx == IDX_W'(N_TESTS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_start <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_mask  <= '0;
            r_fail  <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (go) begin
                        r_mask  <= '0;
                        r_fail  <= '0;
                        r_idx   <= '0;
                        r_cnt   <= '0;
                        r_start <= N_TESTS'(1);
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A finish seen on the timeout edge still counts as a pass.
                    if (w_cur_fin) begin
                        r_start <= '0;
                        r_state <= S_GAP;
                    end else if (w_cnt_max) begin
                        r_mask[r_idx] <= 1'b1;
                        r_fail        <= r_fail + FC_W'(1);
                        r_start       <= '0;
                        r_state       <= S_GAP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_GAP: begin
                    if (w_last) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_idx   <= r_idx + IDX_W'(1);
                        r_start <= N_TESTS'(1) << (r_idx + IDX_W'(1));
                        r_cnt   <= '0;
                        r_state <= S_WAIT;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign start        = r_start;
    assign busy         = r_busy;
    assign done         = r_done;
    assign cur_idx      = r_idx;
    assign timeout_mask = r_mask;
    assign fail_count   = r_fail;

endmodule

// File: tb/tb_test_sequencer.sv
// Scoreboard bench for test_sequencer: behavioural test units drive finish with
// mid-cycle jitter; a schedule model predicts every start/done edge and the final mask.
module tb_test_sequencer;

    localparam int N  = 4;
    localparam int T  = 16;
    localparam int IW = 2;
    localparam int FW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          go  = 1'b0;
    logic [N-1:0]  finish;
    logic [N-1:0]  start;
    logic          busy;
    logic          done;
    logic [IW-1:0] cur_idx;
    logic [N-1:0]  timeout_mask;
    logic [FW-1:0] fail_count;

    test_sequencer #(.N_TESTS(N), .TIMEOUT(T)) dut (
        .clk          (clk),
        .rst          (rst),
        .go           (go),
        .finish       (finish),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .cur_idx      (cur_idx),
        .timeout_mask (timeout_mask),
        .fail_count   (fail_count)
    );

    always #5 clk = ~clk;

    int edge_no = 0;
    always @(posedge clk) edge_no <= edge_no + 1;

    typedef struct {
        bit           is_done;
        int           idx;
        int           cyc;
        logic [N-1:0] mask;
        int           fc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;
    int   gen = 0;
    int   runs_seen = 0;
    int   k_cfg[N];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    // Behavioural test units: finish rises k cycles (plus jitter) after start, and stays high.
    for (genvar u = 0; u < N; u++) begin : g_unit
        logic fin_r = 1'b0;
        int   fin_g = -1;
        assign finish[u] = fin_r && (fin_g == gen);
        initial begin
            int k;
            int gg;
            forever begin
                @(posedge start[u]);
                k  = k_cfg[u];
                gg = gen;
                if (k >= 0) begin
                    repeat (k) @(posedge clk);
                    #($urandom_range(1, 8));
                    fin_g = gg;
                    fin_r = 1'b1;
                end
            end
        end
    end

    // Monitor: compare every start rise and done rise against the scoreboard.
    logic [N-1:0] prev_start = '0;
    logic         prev_done  = 1'b0;
    logic [N-1:0] rise;
    exp_t         me;

    always @(negedge clk) begin
        rise = start & ~prev_start;
        if (rise != '0) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_start: start=%b at edge %0d with empty queue", start, edge_no);
            end else begin
                me = sb.pop_front();
                chk("start_kind", int'(me.is_done), 0);
                chk("start_bit", int'(rise), 1 << me.idx);
                chk("start_edge", edge_no, me.cyc);
                chk("start_onehot", $countones(start), 1);
                chk("busy_at_start", int'(busy), 1);
                chk("done_at_start", int'(done), 0);
                chk("idx_at_start", int'(cur_idx), me.idx);
            end
        end
        if (done && !prev_done) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_done: done rose at edge %0d with empty queue", edge_no);
            end else begin
                me = sb.pop_front();
                chk("done_kind", int'(me.is_done), 1);
                chk("done_edge", edge_no, me.cyc);
                chk("timeout_mask", int'(timeout_mask), int'(me.mask));
                chk("fail_count", int'(fail_count), me.fc);
                chk("busy_at_done", int'(busy), 0);
                chk("idx_at_done", int'(cur_idx), N - 1);
                chk("start_at_done", int'(start), 0);
            end
            runs_seen++;
        end
        prev_start = start;
        prev_done  = done;
    end

    // Schedule model: each unit occupies k+4 cycles on a pass, TIMEOUT+1 on a
    // timeout, 2 if its finish is already high; go is sampled on the next edge.
    task automatic launch();
        int           t;
        logic [N-1:0] m;
        int           fc;
        exp_t         e;
        @(negedge clk);
        t  = edge_no + 1;
        m  = '0;
        fc = 0;
        for (int i = 0; i < N; i++) begin
            e.is_done = 1'b0; e.idx = i; e.cyc = t; e.mask = '0; e.fc = 0;
            sb.push_back(e);
            if (finish[i]) t += 2;
            else if (k_cfg[i] < 0 || k_cfg[i] > T - 3) begin
                t += T + 1;
                m[i] = 1'b1;
                fc++;
            end else t += k_cfg[i] + 4;
        end
        e.is_done = 1'b1; e.idx = N - 1; e.cyc = t; e.mask = m; e.fc = fc;
        sb.push_back(e);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int target;
        int n;
        target = runs_seen + 1;
        n = 0;
        while (runs_seen < target && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (runs_seen >= target) passes++;
        else $display("FAIL %s: done not seen within %0d cycles", nm, n);
        @(negedge clk);
        chk({nm, "_queue_empty"}, sb.size(), 0);
    endtask

    task automatic do_reset();
        gen++;
        sb.delete();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    initial begin
        int n;
        for (int i = 0; i < N; i++) k_cfg[i] = 5;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_start", int'(start), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_idx", int'(cur_idx), 0);
        chk("rst_mask", int'(timeout_mask), 0);
        chk("rst_fc", int'(fail_count), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // All units pass with k=5: starts at +0,+9,+18,+27, done at +36
        launch();
        wait_done("all_pass");
        do_reset();

        // Unit 2 hangs
        k_cfg = '{5, 5, -1, 5};
        launch();
        wait_done("one_hang");
        do_reset();

        // k=13 is the last pass (finish_s meets count 15); k=14 times out
        k_cfg = '{3, 13, 14, 0};
        launch();
        wait_done("boundary");
        repeat (3) @(negedge clk);

        // Restart from DONE with every finish still high; go while busy is ignored
        launch();
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        wait_done("stale_rerun");
        do_reset();

        // Reset mid-run while unit 1 is waiting
        k_cfg = '{5, 5, 5, 5};
        launch();
        n = 0;
        while (!start[1] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("reach_unit1", int'(start[1]), 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_start", int'(start), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_idx", int'(cur_idx), 0);
        chk("midrst_mask", int'(timeout_mask), 0);
        chk("midrst_fc", int'(fail_count), 0);
        gen++;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("idle_start", int'(start), 0);
        chk("idle_busy", int'(busy), 0);
        chk("idle_done", int'(done), 0);

        // Randomized unit response times, including hangs and near-timeout finishes
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < N; i++)
                k_cfg[i] = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 16));
            launch();
            wait_done("random_run");
            do_reset();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/test_sequencer.md
# test_sequencer

Drives the start/finish handshake of a bank of self-checking test units. Pulses each unit's `start` in turn, waits for its sticky `finish`, enforces a per-unit cycle timeout, and reports completion and a timeout mask. It sits at the top of the simulation harness above the per-feature test units (status, ALU, memory, and so on), which each wrap a `mips` instance. It replaces hand-written sequencing of `start` signals in the top-level bench.

## Interface
- `N_TESTS`, 4: number of test units driven (≥1).
- `TIMEOUT`, 1024: cycles a unit may hold `start` high without `finish` before it is declared timed out (≥2).
- `CNT_W`, `$clog2(TIMEOUT)`: width of the wait counter (derived).
- `IDX_W`, `max(1, $clog2(N_TESTS))`: width of `cur_idx` (derived).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `go`  in  1  launch request; sampled only in IDLE and DONE.
- `finish`  in  N_TESTS  per-unit completion flag; level, sticky; may be asynchronous to `clk`.
- `start`  out  N_TESTS  per-unit launch; at most one bit high at a time.
- `busy`  out  1  high in WAIT and GAP.
- `done`  out  1  high in DONE.
- `cur_idx`  out  IDX_W  index of the unit currently being run, or last run.
- `timeout_mask`  out  N_TESTS  bit i set if unit i timed out in the current run.
- `fail_count`  out  `$clog2(N_TESTS+1)`  number of bits set in `timeout_mask`.

## Operation
- **Reset values:** `rst` high forces every output and all internal state to 0 immediately (asynchronous). State goes to IDLE. This applies mid-run; `start` drops without waiting for a clock.
- **Synchronizer:** `finish` passes through a 2-flop synchronizer. The FSM uses only the synchronized `finish_s`.
- **FSM states:** IDLE, WAIT, GAP, DONE. All outputs are registered.
- **IDLE:**
  - If `go`: clear `timeout_mask` and `fail_count`, set `cur_idx`=0, raise `start[0]`, clear the counter, go to WAIT.
  - Otherwise stay.
- **WAIT:** the counter increments every cycle.
  - If `finish_s[cur_idx]`: drop `start`, go to GAP.
  - Else if counter == TIMEOUT−1: set `timeout_mask[cur_idx]`, increment `fail_count`, drop `start`, go to GAP.
  - `finish_s` takes priority if both conditions hold on the same edge (that case is a pass).
- **GAP:** exactly one cycle, with all `start` bits low.
  - If `cur_idx` == N_TESTS−1: go to DONE.
  - Else: increment `cur_idx`, raise the next `start` bit, clear the counter, go to WAIT.
- **DONE:**
  - `done` is held high.
  - `go` restarts the run exactly as from IDLE, and `done` drops on that edge.
- **`go` while busy:** ignored.
- **Stale `finish`:** units never clear `finish`. On a rerun, any `finish` bit already high completes that unit on its first WAIT edge. This is intended behaviour.
- **Counter range:** the counter never wraps. It is cleared on every WAIT entry, and its maximum value is TIMEOUT−1.

## Timing
- `go` sampled at edge 0 → `start[0]` high after edge 0.
- Time references below:
  - `start[i]` rises at edge t.
  - The bench raises `finish[i]` just after edge t+k.
- Resulting sequence:
  - `finish_s` goes high at edge t+k+2.
  - `start[i]` drops at edge t+k+3.
  - Next `start` (or `done`) rises at edge t+k+4.
  - Per-unit occupancy is k+4 cycles.
- **Timeout:** `start[i]` stays high for exactly TIMEOUT cycles. It drops at edge t+TIMEOUT, and `timeout_mask[i]` rises on the same edge.
- **Latencies:** `busy`/`done` follow state with 0 added latency (registered with the state).

## Structure
- Package `test_seq_pkg`:
  - State enum `seq_state_t` (IDLE, WAIT, GAP, DONE).
  - Width helper function (`clog2` with a minimum of 1).
- Sub-module `sync_2ff`: parameterised width, asynchronous active-high reset to 0, instantiated once with width N_TESTS.
- Top level: FSM, wait counter, index register, mask and count registers.

## Test plan
All scenarios use N_TESTS=4 and TIMEOUT=16.
1. **All units pass:** `go` at edge 0; each unit raises `finish` 5 cycles after its `start` → `start` bits rise at edges 0, 9, 18, 27; `done`=1 after edge 36; `timeout_mask`=4'b0000; `fail_count`=0.
2. **One unit hangs:** `finish[2]` is never raised → `start[2]` is high for exactly 16 cycles; `timeout_mask`=4'b0100; `fail_count`=1; units 3 and `done` still complete.
3. **Simultaneous finish and timeout:** `finish_s[1]` rises on the same edge the counter reaches 15 → counted as a pass; `timeout_mask[1]`=0.
4. **Reset mid-run:** `rst` pulsed while in WAIT for unit 1 → `start`, `busy`, `cur_idx`, `timeout_mask` and `fail_count` are 0 before the next edge; with `go` low afterwards, the block stays idle.
5. **Restart with stale `finish`:** `go` pulsed while busy has no effect. `go` in DONE with all `finish` bits still high:
   - the mask is cleared;
   - each unit completes 1 cycle after `start` rises;
   - `done` returns after 8 cycles.
6. **Asynchronous `finish` edges:** `finish` edges land mid-cycle → the observed response equals scenario 1 with k rounded up to the next edge.
